ame_solver_sched: RTL and testbench

Round-robin scheduler that shares one affine-model equation solver (6x7 augmented-matrix Gaussian-elimination engine, 4- or 6-parameter mode) between NUM_REQ affine-motion-estimation requesters. It accepts one matrix job at a time and holds the matrix stable for the whole solve. It pulses the solver start, waits for done under a watchdog, and returns the tagged result through a valid/ready response port. It sits between the per-candidate AME gradient accumulators and the shared solver instance.

---
 rtl/ame_solver_sched.sv | 152 +++++++++++++++
 tb/tb_ame_solver_sched.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ame_solver_sched.sv
// ame_solver_sched: round-robin scheduler sharing one affine-model equation
// solver (6x7 augmented matrix, 4- or 6-parameter mode) between NUM_REQ
// requesters. One job is in flight at a time. The accepted matrix is held on
// slv_data_o until the next accept. Results, or a watchdog error, return
// tagged with the requester index through a valid/ready response port.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   req_valid_i/req_ready_o   per-requester job handshake (ready is one-hot, combinational)
//   req_param6_i, req_data_i  per-requester mode and augmented matrix
//   slv_init_o                one-cycle solver start pulse
//   slv_param6_o, slv_data_o  latched job to the solver
//   slv_done_i, slv_data_i    solver completion pulse and results X0..X5
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_id_o, rsp_err_o       owner index and watchdog-timeout flag
//   rsp_data_o                results (X0/X1 zero in 4-param mode, all zero on error)
//   busy_o                    high whenever a job is in flight
module ame_solver_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned REQ_IDX_BITS   = 2,
  parameter int unsigned COMP_DATA_BITS = 64,
  parameter int unsigned TIMEOUT        = 64,
  localparam int unsigned NUM_X         = 6,
  localparam int unsigned NUM_COL       = 7
) (
  input  logic                                                    clk_i,
  input  logic                                                    rst_i,
  input  logic [NUM_REQ-1:0]                                      req_valid_i,
  output logic [NUM_REQ-1:0]                                      req_ready_o,
  input  logic [NUM_REQ-1:0]                                      req_param6_i,
  input  logic [NUM_REQ-1:0][NUM_X-1:0][NUM_COL-1:0][COMP_DATA_BITS-1:0] req_data_i,
  output logic                                                    slv_init_o,
  output logic                                                    slv_param6_o,
  output logic [NUM_X-1:0][NUM_COL-1:0][COMP_DATA_BITS-1:0]       slv_data_o,
  input  logic                                                    slv_done_i,
  input  logic [NUM_X-1:0][COMP_DATA_BITS-1:0]                    slv_data_i,
  output logic                                                    rsp_valid_o,
  input  logic                                                    rsp_ready_i,
  output logic [REQ_IDX_BITS-1:0]                                 rsp_id_o,
  output logic                                                    rsp_err_o,
  output logic [NUM_X-1:0][COMP_DATA_BITS-1:0]                    rsp_data_o,
  output logic                                                    busy_o
);

  localparam int unsigned CNT_BITS = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_RESP} state_e;

  state_e                               state_q, state_d;
  logic [REQ_IDX_BITS-1:0]              rr_ptr_q;
  logic [CNT_BITS-1:0]                  cnt_q;
  logic [NUM_REQ-1:0]                   grant_c;
  logic [REQ_IDX_BITS-1:0]              grant_idx_c;
  logic                                 grant_vld_c;
  logic                                 timeout_c;
  logic [NUM_X-1:0][COMP_DATA_BITS-1:0] result_c;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
  always_comb begin : arb_scan
    int unsigned k;
    k           = 0;
    grant_c     = '0;
    grant_idx_c = '0;
    grant_vld_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_vld_c && req_valid_i[REQ_IDX_BITS'(k)]) begin
        grant_vld_c                      = 1'b1;
        grant_idx_c                      = REQ_IDX_BITS'(k);
        grant_c[REQ_IDX_BITS'(k)]        = 1'b1;
      end
    end
  end

  assign timeout_c = (cnt_q == CNT_BITS'(TIMEOUT - 1));

  // Solver results; X0/X1 carry no meaning in 4-param mode.
  always_comb begin
    result_c = slv_data_i;
    if (!slv_param6_o) begin
      result_c[0] = '0;
      result_c[1] = '0;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; done has priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_vld_c) state_d = ST_LAUNCH;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (slv_done_i || timeout_c) state_d = ST_RESP;
      ST_RESP:   if (rsp_ready_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    req_ready_o = '0;
    slv_init_o  = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = grant_c;
        busy_o      = 1'b0;
      end
      ST_LAUNCH: slv_init_o  = 1'b1;
      ST_RESP:   rsp_valid_o = 1'b1;
      default:   ;
    endcase
  end

  // Job latch, round-robin pointer, watchdog counter and result register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      slv_data_o   <= '0;
      slv_param6_o <= 1'b0;
      rsp_id_o     <= '0;
      rsp_err_o    <= 1'b0;
      rsp_data_o   <= '0;
    end else begin
      if (state_q == ST_IDLE && grant_vld_c) begin
        slv_data_o   <= req_data_i[grant_idx_c];
        slv_param6_o <= req_param6_i[grant_idx_c];
        rsp_id_o     <= grant_idx_c;
        rr_ptr_q     <= (32'(grant_idx_c) == NUM_REQ - 1) ? '0 : grant_idx_c + REQ_IDX_BITS'(1);
      end
      if (state_q == ST_LAUNCH) cnt_q <= '0;
      else if (state_q == ST_WAIT) cnt_q <= cnt_q + CNT_BITS'(1);
      if (state_q == ST_WAIT) begin
        if (slv_done_i) begin
          rsp_data_o <= result_c;
          rsp_err_o  <= 1'b0;
        end else if (timeout_c) begin
          rsp_data_o <= '0;
          rsp_err_o  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ame_solver_sched.sv
// Testbench for ame_solver_sched: directed jobs against a timestamp-based
// transaction model plus literal expectations for grant order and latencies.
module tb_ame_solver_sched;

  localparam int NUM_REQ = 4;
  localparam int IB      = 2;
  localparam int DW      = 64;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic [NUM_REQ-1:0]                 req_param6_i;
  logic [NUM_REQ-1:0][5:0][6:0][DW-1:0] req_data_i;
  logic                               slv_init_o;
  logic                               slv_param6_o;
  logic [5:0][6:0][DW-1:0]            slv_data_o;
  logic                               slv_done_i;
  logic [5:0][DW-1:0]                 slv_data_i;
  logic                               rsp_valid_o;
  logic                               rsp_ready_i;
  logic [IB-1:0]                      rsp_id_o;
  logic                               rsp_err_o;
  logic [5:0][DW-1:0]                 rsp_data_o;
  logic                               busy_o;

  ame_solver_sched #(
    .NUM_REQ(NUM_REQ), .REQ_IDX_BITS(IB), .COMP_DATA_BITS(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_param6_i(req_param6_i), .req_data_i(req_data_i),
    .slv_init_o(slv_init_o), .slv_param6_o(slv_param6_o), .slv_data_o(slv_data_o),
    .slv_done_i(slv_done_i), .slv_data_i(slv_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o), .rsp_data_o(rsp_data_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int arb(input logic [NUM_REQ-1:0] v, input int ptr);
    int r;
    r = -1;
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (ptr + i) % NUM_REQ;
      if (r < 0 && v[IB'(k)]) r = k;
    end
    return r;
  endfunction

  // Solver stand-in: done sol_lat cycles after init (never if negative);
  // stray_req forces an extra done pulse carrying junk data.
  int                 sol_lat = 20;
  logic [5:0][DW-1:0] sol_res = '0;
  bit                 stray_req = 1'b0;

  initial begin
    int due;
    due = -1;
    slv_done_i = 1'b0;
    slv_data_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (slv_init_o && sol_lat >= 0) due = cyc + sol_lat;
      if (cyc == due) begin
        slv_done_i = 1'b1;
        slv_data_i = sol_res;
        due = -1;
      end else if (stray_req) begin
        slv_done_i = 1'b1;
        slv_data_i = ~sol_res;
      end else begin
        slv_done_i = 1'b0;
        slv_data_i = {6{64'hDEAD_BEEF_0BAD_F00D}};
      end
    end
  end

  // Transaction model: one job at a time, grant by round-robin rule,
  // init the cycle after accept, response the cycle after done or after
  // TIMEOUT cycles of waiting, held until accepted.
  bit                      chk_en = 1'b0;
  bit                      m_act = 1'b0;
  int                      m_ptr = 0;
  int                      m_acc = 0;
  int                      m_rsp_at = -1;
  int                      m_id = 0;
  bit                      m_err = 1'b0;
  bit                      m_p6 = 1'b0;
  logic [5:0][DW-1:0]      m_data = '0;
  logic [5:0][6:0][DW-1:0] m_slv = '0;

  int acc_ids[$];
  int last_acc_cyc = 0, last_acc_id = -1, last_rise_cyc = 0, last_hs_cyc = 0;
  bit prev_rv = 1'b0;

  always @(negedge clk) begin
    int g;
    bit exp_rv;
    logic [NUM_REQ-1:0] exp_rdy;
    g = arb(req_valid_i, m_ptr);
    exp_rv = m_act && m_rsp_at >= 0 && cyc >= m_rsp_at;
    exp_rdy = '0;
    if (!m_act && g >= 0) exp_rdy[IB'(g)] = 1'b1;
    if (chk_en) begin
      chk1("busy", busy_o, m_act);
      chk_int("req_ready", int'(req_ready_o), int'(exp_rdy));
      chk1("slv_init", slv_init_o, m_act && cyc == m_acc + 1);
      chk1("rsp_valid", rsp_valid_o, exp_rv);
      chk1("slv_param6", slv_param6_o, m_p6);
      chk1("slv_data_hold", slv_data_o == m_slv, 1'b1);
      if (exp_rv) begin
        chk_int("rsp_id", int'(rsp_id_o), m_id);
        chk1("rsp_err", rsp_err_o, m_err);
        chk_vec("rsp_data", rsp_data_o, m_data);
      end
    end
    // DUT-side observations used by the directed checks
    if (!rst_i && (req_valid_i & req_ready_o) != '0) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready_o[IB'(i)]) last_acc_id = i;
      last_acc_cyc = cyc;
      acc_ids.push_back(last_acc_id);
    end
    if (rsp_valid_o && !prev_rv) last_rise_cyc = cyc;
    prev_rv = rsp_valid_o;
    if (!rst_i && rsp_valid_o && rsp_ready_i) last_hs_cyc = cyc;
    // advance model to the next cycle
    if (rst_i) begin
      m_act = 1'b0; m_ptr = 0; m_p6 = 1'b0; m_slv = '0; m_rsp_at = -1;
    end else if (!m_act) begin
      if (g >= 0) begin
        m_act = 1'b1; m_acc = cyc; m_id = g; m_ptr = (g + 1) % NUM_REQ;
        m_p6 = req_param6_i[IB'(g)]; m_slv = req_data_i[IB'(g)]; m_rsp_at = -1;
      end
    end else if (m_rsp_at < 0) begin
      if (cyc >= m_acc + 2) begin
        if (slv_done_i) begin
          m_rsp_at = cyc + 1; m_err = 1'b0; m_data = slv_data_i;
          if (!m_p6) begin m_data[0] = '0; m_data[1] = '0; end
        end else if (cyc - (m_acc + 2) == TIMEOUT - 1) begin
          m_rsp_at = cyc + 1; m_err = 1'b1; m_data = '0;
        end
      end
    end else if (exp_rv && rsp_ready_i) begin
      m_act = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name, input int maxc);
    int n;
    n = 0;
    do begin step(); n++; end while (!slv_init_o && n < maxc);
    checks++;
    if (!slv_init_o) begin
      failures++;
      $display("FAIL %s: no slv_init_o within %0d cycles", name, maxc);
    end
  endtask

  // Ends half a cycle into the first rsp_valid cycle so observation logs are current.
  task automatic wait_rsp(input string name, input int maxc);
    int n;
    n = 0;
    do begin step(); n++; end while (!rsp_valid_o && n < maxc);
    checks++;
    if (!rsp_valid_o) begin
      failures++;
      $display("FAIL %s: no rsp_valid_o within %0d cycles", name, maxc);
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int exp_order[5];
    logic [5:0][DW-1:0] zero6;
    exp_order = '{0, 1, 2, 3, 0};
    zero6 = '0;
    req_valid_i = '0;
    req_param6_i = '0;
    rsp_ready_i = 1'b1;
    for (int r = 0; r < NUM_REQ; r++)
      for (int i = 0; i < 6; i++)
        for (int j = 0; j < 7; j++)
          req_data_i[IB'(r)][3'(i)][3'(j)] = {16'(r), 16'(i), 16'(j), 16'hA5A5};
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk_en = 1'b1;

    // reset values
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_rsp_valid", rsp_valid_o, 1'b0);
    chk1("rst_slv_init", slv_init_o, 1'b0);
    chk1("rst_rsp_err", rsp_err_o, 1'b0);
    chk_int("rst_rsp_id", int'(rsp_id_o), 0);
    chk_vec("rst_rsp_data", rsp_data_o, zero6);
    chk1("rst_slv_param6", slv_param6_o, 1'b0);
    chk1("rst_slv_data_zero", slv_data_o == '0, 1'b1);

    // round robin with all requesters valid: 0,1,2,3,0
    base = acc_ids.size();
    req_param6_i = 4'hF;
    for (int i = 0; i < 6; i++) sol_res[i] = 64'h100 + 64'(i);
    sol_lat = 20;
    req_valid_i = 4'hF;
    for (int k = 0; k < 5; k++) wait_init("rr_init", 40);
    req_valid_i = '0;
    wait_rsp("rr_last_rsp", 40);
    chk_int("rr_accept_count", acc_ids.size() - base, 5);
    if (acc_ids.size() - base >= 5)
      for (int k = 0; k < 5; k++) chk_int($sformatf("rr_grant%0d", k), acc_ids[base + k], exp_order[k]);

    // single 6-param job from requester 2, diagonal system
    step();
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 7; j++)
        req_data_i[2][3'(i)][3'(j)] = (j == i) ? 64'h2_0000 : (j == 6) ? 64'h4_0000 : 64'h0;
    for (int i = 0; i < 6; i++) sol_res[i] = 64'h2_0000 + 64'(i);
    req_param6_i[2] = 1'b1;
    req_valid_i = 4'b0100;
    wait_init("t1_init", 10);
    req_valid_i = '0;
    chk_int("t1_grant", last_acc_id, 2);
    chk1("t1_slv_param6", slv_param6_o, 1'b1);
    chk_vec("t1_slv_a22", {320'h0, slv_data_o[2][2]}, {320'h0, 64'h2_0000});
    chk_vec("t1_slv_b3", {320'h0, slv_data_o[3][6]}, {320'h0, 64'h4_0000});
    wait_rsp("t1_rsp", 40);
    chk_int("t1_latency", last_rise_cyc - last_acc_cyc, 22);
    chk_int("t1_rsp_id", int'(rsp_id_o), 2);
    chk1("t1_rsp_err", rsp_err_o, 1'b0);
    chk_vec("t1_rsp_x5", {320'h0, rsp_data_o[5]}, {320'h0, 64'h2_0005});
    chk_vec("t1_rsp_x0", {320'h0, rsp_data_o[0]}, {320'h0, 64'h2_0000});

    // 4-param job from requester 0: X0/X1 forced to zero
    step();
    for (int i = 0; i < 6; i++) sol_res[i] = 64'h7700 + 64'(i);
    req_param6_i[0] = 1'b0;
    sol_lat = 14;
    req_valid_i = 4'b0001;
    wait_init("t3_init", 10);
    req_valid_i = '0;
    chk1("t3_slv_param6", slv_param6_o, 1'b0);
    wait_rsp("t3_rsp", 40);
    chk_int("t3_latency", last_rise_cyc - last_acc_cyc, 16);
    chk_vec("t3_rsp_x0", {320'h0, rsp_data_o[0]}, 384'h0);
    chk_vec("t3_rsp_x1", {320'h0, rsp_data_o[1]}, 384'h0);
    chk_vec("t3_rsp_x2", {320'h0, rsp_data_o[2]}, {320'h0, 64'h7702});
    chk_vec("t3_rsp_x5", {320'h0, rsp_data_o[5]}, {320'h0, 64'h7705});

    // watchdog timeout, requester 3
    step();
    sol_lat = -1;
    req_param6_i[3] = 1'b1;
    req_valid_i = 4'b1000;
    wait_init("t4_init", 10);
    req_valid_i = '0;
    wait_rsp("t4_rsp", 100);
    chk_int("t4_latency", last_rise_cyc - last_acc_cyc, 66);
    chk1("t4_rsp_err", rsp_err_o, 1'b1);
    chk_vec("t4_rsp_data", rsp_data_o, zero6);
    chk_int("t4_rsp_id", int'(rsp_id_o), 3);

    // done in the same cycle as the watchdog expiry: done wins
    step();
    for (int i = 0; i < 6; i++) sol_res[i] = 64'h5500 + 64'(i);
    sol_lat = TIMEOUT;
    req_param6_i[1] = 1'b1;
    req_valid_i = 4'b0010;
    wait_init("t5_init", 10);
    req_valid_i = '0;
    wait_rsp("t5_rsp", 100);
    chk_int("t5_latency", last_rise_cyc - last_acc_cyc, 66);
    chk1("t5_rsp_err", rsp_err_o, 1'b0);
    chk_vec("t5_rsp_data", rsp_data_o, sol_res);

    // response back-pressure with requester 1 pending and stray done pulses
    step();
    for (int i = 0; i < 6; i++) sol_res[i] = 64'h6600 + 64'(i);
    sol_lat = 20;
    req_param6_i[0] = 1'b1;
    req_valid_i = 4'b0001;
    wait_init("t6_init", 10);
    req_valid_i = 4'b0010;
    rsp_ready_i = 1'b0;
    wait_rsp("t6_rsp", 40);
    for (int k = 0; k < 10; k++) begin
      step();
      stray_req = (k >= 2 && k <= 4);
      chk1("t6_hold_valid", rsp_valid_o, 1'b1);
      chk_int("t6_hold_id", int'(rsp_id_o), 0);
      chk_vec("t6_hold_data", rsp_data_o, sol_res);
      chk_int("t6_hold_ready", int'(req_ready_o), 0);
    end
    stray_req = 1'b0;
    rsp_ready_i = 1'b1;
    wait_init("t6_next_init", 10);
    req_valid_i = '0;
    @(negedge clk);
    #1;
    chk_int("t6_next_grant", last_acc_id, 1);
    chk_int("t6_accept_after_hs", last_acc_cyc - last_hs_cyc, 1);
    wait_rsp("t6_next_rsp", 40);
    chk_int("t6_next_rsp_id", int'(rsp_id_o), 1);

    // reset while waiting: job dropped, pointer back to 0
    step();
    req_param6_i[2] = 1'b1;
    req_valid_i = 4'b0100;
    wait_init("t7_init", 10);
    req_valid_i = '0;
    repeat (5) step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk1("t7_rst_busy", busy_o, 1'b0);
    chk1("t7_rst_param6", slv_param6_o, 1'b0);
    chk1("t7_rst_slv_data_zero", slv_data_o == '0, 1'b1);
    chk_int("t7_rst_rsp_id", int'(rsp_id_o), 0);
    chk1("t7_rst_rsp_err", rsp_err_o, 1'b0);
    chk_vec("t7_rst_rsp_data", rsp_data_o, zero6);
    for (int k = 0; k < 25; k++) begin
      step();
      chk1("t7_no_rsp", rsp_valid_o, 1'b0);
    end
    req_param6_i[1] = 1'b1;
    req_param6_i[3] = 1'b1;
    req_valid_i = 4'b1010;
    wait_init("t7_next_init", 10);
    req_valid_i = '0;
    chk_int("t7_next_grant", last_acc_id, 1);
    wait_rsp("t7_next_rsp", 40);
    chk_int("t7_next_rsp_id", int'(rsp_id_o), 1);

    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
